// File: rtl/clkrst_gen.sv
// rtl/clkrst_gen.sv - staged reset sequencer and sample-rate clock generator
//
// Purpose: after reset, hold every reset output for RST_CYCLES clocks, then
// release them one at a time STAGE_GAP clocks apart (bit 0 first). Once
// rst_out[0] drops, a phase counter runs and produces a clk_fs square wave
// at clk_256fs/DIV plus a one-cycle strobe on each clk_fs rising edge.
//
// Ports:
//   clk_256fs  in   sole clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   rst_req    in   synchronous request to re-run the reset sequence
//   rst_out    out  [N_RST] staged active-high resets, bit 0 released first
//   ready      out  high once every rst_out bit is released
//   clk_fs     out  50% duty square wave, period DIV
//   fs_strobe  out  one-cycle pulse coincident with the clk_fs rising edge
//   fs_phase   out  [$clog2(DIV)] position within the sample period
//
// Build option: define RST_STAGGER_EN for staggered release of rst_out bits;
// without it every bit is released together and there is no stage counter.

module clkrst_gen #(
  parameter int DIV        = 256,
  parameter int RST_CYCLES = 128,
  parameter int N_RST      = 2,
  parameter int STAGE_GAP  = 16
) (
  input  logic                    clk_256fs,
  input  logic                    rst,
  input  logic                    rst_req,
  output logic [N_RST-1:0]        rst_out,
  output logic                    ready,
  output logic                    clk_fs,
  output logic                    fs_strobe,
  output logic [$clog2(DIV)-1:0]  fs_phase
);

  localparam int PW = $clog2(DIV);
  localparam int SW = $clog2(RST_CYCLES + 1);

  // Reject illegal configurations at elaboration.
  if (DIV < 4 || (DIV % 2) != 0 || RST_CYCLES < 1 || N_RST < 1 || STAGE_GAP < 1) begin : g_bad_param
    $error("clkrst_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_stretch, w_stretch_nxt;
  logic [N_RST-1:0] r_rst_out, w_rst_out_nxt;
  logic             r_ready, w_ready_nxt;
  logic [PW-1:0]    r_phase, w_phase_nxt;
  logic             r_clk_fs, w_clk_fs_nxt;
  logic             r_strobe, w_strobe_nxt;

`ifdef RST_STAGGER_EN
  localparam int STAGE_MAX = (N_RST - 1) * STAGE_GAP;
  localparam int STW       = (STAGE_MAX < 1) ? 1 : $clog2(STAGE_MAX + 1);

  // Cycles elapsed since rst_out[0] was released.
  logic [STW-1:0] r_stage, w_stage_nxt;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_stretch_nxt = r_stretch;
    w_rst_out_nxt = r_rst_out;
    w_ready_nxt   = r_ready;
`ifdef RST_STAGGER_EN
    w_stage_nxt   = r_stage;
`endif

    // Phase stays parked at 0 until the first stage leaves reset.
    if (r_rst_out[0]) begin
      w_phase_nxt = '0;
    end else if (r_phase == PW'(DIV - 1)) begin
      w_phase_nxt = '0;
    end else begin
      w_phase_nxt = r_phase + PW'(1);
    end

    case (r_state)
      HOLD: begin
        w_rst_out_nxt = '1;
        w_ready_nxt   = 1'b0;
        if (r_stretch == SW'(RST_CYCLES - 1)) begin
`ifdef RST_STAGGER_EN
          if (N_RST == 1) begin
            w_state_nxt   = RUN;
            w_rst_out_nxt = '0;
            w_ready_nxt   = 1'b1;
          end else begin
            w_state_nxt      = STAGGER;
            w_rst_out_nxt[0] = 1'b0;
            w_stage_nxt      = '0;
          end
`else
          w_state_nxt   = RUN;
          w_rst_out_nxt = '0;
          w_ready_nxt   = 1'b1;
`endif
        end else begin
          w_stretch_nxt = r_stretch + SW'(1);
        end
      end

      STAGGER: begin
`ifdef RST_STAGGER_EN
        w_stage_nxt = r_stage + STW'(1);
        for (int k = 1; k < N_RST; k++) begin
          if (w_stage_nxt >= STW'(k * STAGE_GAP)) begin
            w_rst_out_nxt[k] = 1'b0;
          end
        end
        if (w_stage_nxt == STW'(STAGE_MAX)) begin
          w_state_nxt = RUN;
          w_ready_nxt = 1'b1;
        end
`else
        w_state_nxt = HOLD;
`endif
      end

      RUN: begin
        w_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = HOLD;
      end
    endcase

    w_clk_fs_nxt = (w_phase_nxt >= PW'(DIV / 2));
    w_strobe_nxt = (w_phase_nxt == PW'(DIV / 2));
  end

  // rst and rst_req share one restart path; rst has nothing to outrank
  // because both force the identical state.
  always_ff @(posedge clk_256fs) begin
    if (rst || rst_req) begin
      r_state   <= HOLD;
      r_stretch <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_phase   <= '0;
      r_clk_fs  <= 1'b0;
      r_strobe  <= 1'b0;
`ifdef RST_STAGGER_EN
      r_stage   <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_stretch <= w_stretch_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_ready   <= w_ready_nxt;
      r_phase   <= w_phase_nxt;
      r_clk_fs  <= w_clk_fs_nxt;
      r_strobe  <= w_strobe_nxt;
`ifdef RST_STAGGER_EN
      r_stage   <= w_stage_nxt;
`endif
    end
  end

  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign clk_fs    = r_clk_fs;
  assign fs_strobe = r_strobe;
  assign fs_phase  = r_phase;

endmodule

// File: doc/clkrst_gen.md
CLKRST_GEN -- requirements
Module: clkrst_gen

Interface
REQ-001 SHALL have parameter DIV, default 256, meaning clk_256fs cycles per sample period; legal values are even and >= 4.
REQ-002 SHALL have parameter RST_CYCLES, default 128, meaning reset-stretch length in clk_256fs cycles; legal values are >= 1.
REQ-003 SHALL have parameter N_RST, default 2, meaning number of staged reset outputs; legal values are >= 1.
REQ-004 SHALL have parameter STAGE_GAP, default 16, meaning cycles between successive stage releases; legal values are >= 1.
REQ-005 SHALL have port clk_256fs, input, 1 bit: the sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rst_req, input, 1 bit: synchronous request to re-run the reset sequence.
REQ-008 SHALL have port rst_out, output, N_RST bits: staged active-high resets; bit 0 is released first.
REQ-009 SHALL have port ready, output, 1 bit: high once all stages are released.
REQ-010 SHALL have port clk_fs, output, 1 bit: sample-rate square wave.
REQ-011 SHALL have port fs_strobe, output, 1 bit: one-cycle pulse marking the clk_fs rising edge.
REQ-012 SHALL have port fs_phase, output, $clog2(DIV) bits: position within the sample period.

Function
REQ-013 SHALL implement states HOLD, STAGGER and RUN, with all outputs registered.
- HOLD: stretch counter counts RST_CYCLES cycles; all rst_out bits are 1.
REQ-014 SHALL release rst_out[0] on exactly the RST_CYCLES-th rising edge after the first edge sampling rst=0 and rst_req=0.
- On that edge the state goes HOLD->STAGGER, or HOLD->RUN if N_RST=1.
REQ-015 SHALL, in STAGGER, clear rst_out[k] exactly k*STAGE_GAP cycles after rst_out[0] clears.
- Released bits never re-assert except via REQ-021.
REQ-016 SHALL enter RUN and assert ready on the same edge that clears rst_out[N_RST-1].
- ready is 0 in HOLD and STAGGER.
REQ-017 SHALL hold fs_phase at 0 while rst_out[0]=1.
- Afterwards fs_phase increments by 1 per cycle and wraps from DIV-1 to 0.
REQ-018 SHALL drive clk_fs = 1 exactly when fs_phase >= DIV/2, giving a 50% duty cycle with period DIV.
REQ-019 SHALL drive fs_strobe = 1 exactly in cycles where fs_phase == DIV/2, i.e. coincident with the clk_fs rising edge.
- fs_strobe is never high while rst_out[0]=1.
REQ-020 SHALL size the stretch and stage counters as $clog2(max+1) bits so no count wraps before its terminal value.

Reset
REQ-021 SHALL, on any edge sampling rst=1 or rst_req=1 in any state, do all of the following on that edge:
- enter HOLD and clear the stretch and stage counters;
- set rst_out to all ones;
- clear ready, clk_fs, fs_strobe and fs_phase.
REQ-022 SHALL restart the full REQ-014 count when rst or rst_req is held high for multiple cycles, timing from the first edge with both low.
REQ-023 SHALL give rst priority over all other inputs; rst_req behaves identically to rst.

Configuration
REQ-024 SHALL, with macro RST_STAGGER_EN defined, behave as REQ-015/REQ-016 describe.
REQ-025 SHALL, without RST_STAGGER_EN, behave as follows:
- clear all rst_out bits together on the REQ-014 edge;
- go directly HOLD->RUN and assert ready on that edge;
- never enter STAGGER, ignore STAGE_GAP, and omit the stage counter.

Verification (DIV=256, RST_CYCLES=128, N_RST=3, STAGE_GAP=16, RST_STAGGER_EN defined unless noted)
REQ-026 SHALL check: rst high 5 cycles then low -> rst_out=3'b111 for 127 edges; on edge 128, rst_out=3'b110; on edge 144, 3'b100; on edge 160, 3'b000 with ready=1.
REQ-027 SHALL check: after rst_out[0] falls -> fs_phase counts 0..255 and wraps; clk_fs rises when fs_phase=128 with fs_strobe=1 for exactly 1 cycle; strobes are 256 cycles apart.
REQ-028 SHALL check: rst_req pulsed 1 cycle in RUN at fs_phase=200 -> next edge has rst_out=3'b111, ready=0, fs_phase=0, clk_fs=0; rst_out[0] releases 128 edges after the pulse.
REQ-029 SHALL check: rst_req pulsed during STAGGER with rst_out=3'b100 -> rst_out=3'b111 on the next edge, then the full 128/144/160 sequence repeats.
REQ-030 SHALL check, without RST_STAGGER_EN: the REQ-026 stimulus -> rst_out goes 3'b111 -> 3'b000 and ready=1 together on edge 128.
REQ-031 SHALL check: DIV=4, N_RST=1 -> fs_phase sequence 0,1,2,3,0; clk_fs pattern 0,0,1,1; fs_strobe only at phase 2; ready asserts with rst_out[0] release.
